// File: rtl/uart_alu_ctrl_if.sv
// Bundle between the frame sequencer and its UART receiver, transmitter and ALU.
// Latency: none, wires only.
// Backpressure: none; i_Tx_Done is the only return path from the transmitter.
// Ports: i_bd/i_Rx_Done/i_Rx_Byte from the receiver, i_Alu_Result from the ALU,
//        i_Tx_Done from the transmitter; o_* registered outputs of the sequencer.
interface uart_alu_ctrl_if #(
    parameter int Bits    = 8,
    parameter int Op_Bits = 6
);
    logic               i_bd;
    logic               i_Rx_Done;
    logic [Bits-1:0]    i_Rx_Byte;
    logic [Bits-1:0]    i_Alu_Result;
    logic               i_Tx_Done;
    logic [Bits-1:0]    o_A;
    logic [Bits-1:0]    o_B;
    logic [Op_Bits-1:0] o_Op;
    logic               o_Tx_Start;
    logic [Bits-1:0]    o_Tx_Byte;
    logic               o_Busy;
    logic               o_Err_Timeout;
    logic               o_Err_Overrun;

    // Environment side: receiver, ALU and transmitter.
    modport master (
        output i_bd, i_Rx_Done, i_Rx_Byte, i_Alu_Result, i_Tx_Done,
        input  o_A, o_B, o_Op, o_Tx_Start, o_Tx_Byte, o_Busy, o_Err_Timeout, o_Err_Overrun
    );

    // Sequencer side.
    modport slave (
        input  i_bd, i_Rx_Done, i_Rx_Byte, i_Alu_Result, i_Tx_Done,
        output o_A, o_B, o_Op, o_Tx_Start, o_Tx_Byte, o_Busy, o_Err_Timeout, o_Err_Overrun
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Sequencer: collects operand A, operand B and opcode bytes, runs the ALU, sends the result byte.
// Latency: opcode byte event to o_Tx_Start is 2 cycles; all outputs are registered.
// Backpressure: none on receive; bytes arriving while a result is in flight are dropped and flagged.
// Ports: i_Clock, i_reset_n (async active-low) plain; everything else through bus (slave modport).
module uart_alu_ctrl #(
    parameter int Bits          = 8,
    parameter int Op_Bits       = 6,
    parameter int Timeout_Ticks = 160
) (
    input  logic          i_Clock,
    input  logic          i_reset_n,
    uart_alu_ctrl_if.slave bus
);
    localparam int Cnt_W = $clog2(Timeout_Ticks + 1);
    localparam logic [Cnt_W-1:0] Cnt_Max = Cnt_W'(Timeout_Ticks);

    typedef enum logic [2:0] {
        S_GET_A   = 3'd0,
        S_GET_B   = 3'd1,
        S_GET_OP  = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               rx_prev_q;
    logic [Bits-1:0]    a_q, a_d;
    logic [Bits-1:0]    b_q, b_d;
    logic [Op_Bits-1:0] op_q, op_d;
    logic [Bits-1:0]    tx_byte_q, tx_byte_d;
    logic [Cnt_W-1:0]   cnt_q, cnt_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;

    logic               rx_ev;
    logic [Cnt_W-1:0]   cnt_inc;
    logic               tick_out;

    // A done level held for several cycles is one byte.
    assign rx_ev    = bus.i_Rx_Done & ~rx_prev_q;
    assign cnt_inc  = (bus.i_bd && (cnt_q != Cnt_Max)) ? cnt_q + 1'b1 : cnt_q;
    assign tick_out = (cnt_inc == Cnt_Max);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tx_byte_d  = tx_byte_q;
        cnt_d      = '0;       // counter only runs while waiting for B or opcode
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;
        case (state_q)
            S_GET_A: begin
                if (rx_ev) begin
                    a_d     = bus.i_Rx_Byte;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                // A byte arriving on the terminal tick still wins.
                if (rx_ev) begin
                    b_d     = bus.i_Rx_Byte;
                    state_d = S_GET_OP;
                end else if (tick_out) begin
                    timeout_d = 1'b1;
                    state_d   = S_GET_A;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GET_OP: begin
                if (rx_ev) begin
                    op_d    = bus.i_Rx_Byte[Op_Bits-1:0];
                    state_d = S_EXEC;
                end else if (tick_out) begin
                    timeout_d = 1'b1;
                    state_d   = S_GET_A;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_EXEC: begin
                tx_byte_d  = bus.i_Alu_Result;
                tx_start_d = 1'b1;     // registered, so high during S_SEND
                overrun_d  = rx_ev;
                state_d    = S_SEND;
            end
            S_SEND: begin
                overrun_d = rx_ev;
                state_d   = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                overrun_d = rx_ev;
                if (bus.i_Tx_Done) begin
                    state_d = S_GET_A;
                end
            end
            default: state_d = S_GET_A;
        endcase
        busy_d = (state_d != S_GET_A);
    end

    always_ff @(posedge i_Clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_GET_A;
            rx_prev_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_byte_q  <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_prev_q  <= bus.i_Rx_Done;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_byte_q  <= tx_byte_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.o_A           = a_q;
    assign bus.o_B           = b_q;
    assign bus.o_Op          = op_q;
    assign bus.o_Tx_Byte     = tx_byte_q;
    assign bus.o_Tx_Start    = tx_start_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_Err_Timeout = timeout_q;
    assign bus.o_Err_Overrun = overrun_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed scenarios plus randomized frames against a frame-level model.
// Latency: n/a.
// Backpressure: the bench transmitter answers o_Tx_Start with i_Tx_Done after tx_delay cycles.
module tb_uart_alu_ctrl;
    localparam int Bits    = 8;
    localparam int Op_Bits = 6;
    localparam int TT      = 160;

    logic i_Clock   = 1'b0;
    logic i_reset_n = 1'b0;

    uart_alu_ctrl_if #(.Bits(Bits), .Op_Bits(Op_Bits)) bus();

    uart_alu_ctrl #(.Bits(Bits), .Op_Bits(Op_Bits), .Timeout_Ticks(TT)) dut (
        .i_Clock   (i_Clock),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_Clock = ~i_Clock;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return a;
        endcase
    endfunction

    assign bus.i_Alu_Result = alu_f(bus.o_A, bus.o_B, bus.o_Op);

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_tout   = 0;
    int n_ovr    = 0;
    int tx_delay = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: how many bytes of the frame are in hand, and how
    // many cycles have passed since the frame completed.
    int         m_got = 0;
    int         m_age = 0;
    int         m_ticks = 0;
    bit         m_prev = 0;
    bit         m_to = 0;
    bit         m_ov = 0;
    bit         m_ev;
    logic [7:0] m_A = 0, m_B = 0, m_tx = 0;
    logic [5:0] m_Op = 0;

    always @(posedge i_Clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_got = 0; m_age = 0; m_ticks = 0; m_prev = 0; m_to = 0; m_ov = 0;
            m_A = 0; m_B = 0; m_Op = 0; m_tx = 0;
        end else begin
            m_ev   = bus.i_Rx_Done && !m_prev;
            m_prev = bus.i_Rx_Done;
            m_to   = 0;
            m_ov   = 0;
            if (m_got == 3) begin
                if (m_ev) m_ov = 1;
                if (m_age == 0) m_tx = alu_f(m_A, m_B, m_Op);
                if (m_age >= 2 && bus.i_Tx_Done) m_got = 0;
                else if (m_age < 2) m_age++;
            end else if (m_ev) begin
                if (m_got == 0) m_A = bus.i_Rx_Byte;
                else if (m_got == 1) m_B = bus.i_Rx_Byte;
                else m_Op = bus.i_Rx_Byte[5:0];
                m_got++;
                m_ticks = 0;
                m_age = 0;
            end else if (m_got > 0 && bus.i_bd) begin
                m_ticks++;
                if (m_ticks == TT) begin
                    m_to = 1; m_got = 0; m_ticks = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge i_Clock) begin
        chk("o_A", bus.o_A, m_A);
        chk("o_B", bus.o_B, m_B);
        chk("o_Op", bus.o_Op, m_Op);
        chk("o_Tx_Byte", bus.o_Tx_Byte, m_tx);
        chk("o_Tx_Start", bus.o_Tx_Start, (m_got == 3 && m_age == 1));
        chk("o_Busy", bus.o_Busy, (m_got != 0));
        chk("o_Err_Timeout", bus.o_Err_Timeout, m_to);
        chk("o_Err_Overrun", bus.o_Err_Overrun, m_ov);
        if (bus.o_Tx_Start === 1'b1) n_start++;
        if (bus.o_Err_Timeout === 1'b1) n_tout++;
        if (bus.o_Err_Overrun === 1'b1) n_ovr++;
    end

    // Bench transmitter.
    initial begin
        bus.i_Tx_Done = 1'b0;
        forever begin
            @(negedge i_Clock);
            if (bus.o_Tx_Start === 1'b1) begin
                repeat (tx_delay) @(posedge i_Clock);
                #1 bus.i_Tx_Done = 1'b1;
                @(posedge i_Clock);
                #1 bus.i_Tx_Done = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic step(input bit bd, input bit done, input logic [7:0] b);
        @(posedge i_Clock);
        #1;
        bus.i_bd      = bd;
        bus.i_Rx_Done = done;
        bus.i_Rx_Byte = b;
    endtask

    function automatic bit rbd(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold, input int pct);
        for (int i = 0; i < hold; i++) step(rbd(pct), 1'b1, b);
        step(rbd(pct), 1'b0, 8'($urandom));
    endtask

    task automatic idle(input int n, input int pct);
        for (int i = 0; i < n; i++) step(rbd(pct), 1'b0, 8'($urandom));
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (bus.o_Busy !== 1'b0 && k < budget) begin
            step(1'b1, 1'b0, 8'h00);
            k++;
        end
        chk("wait_idle_busy", bus.o_Busy, 1'b0);
    endtask

    int s0, t0, o0, k;

    initial begin
        bus.i_bd = 0; bus.i_Rx_Done = 0; bus.i_Rx_Byte = 0;
        repeat (3) @(posedge i_Clock);
        #1;
        chk("rst_A", bus.o_A, 0);
        chk("rst_Tx_Byte", bus.o_Tx_Byte, 0);
        chk("rst_Busy", bus.o_Busy, 0);
        chk("rst_Tx_Start", bus.o_Tx_Start, 0);
        i_reset_n = 1'b1;
        idle(2, 0);

        // Basic frame, latency and result.
        tx_delay = 3;
        send_byte(8'h05, 1, 0);
        send_byte(8'h03, 1, 0);
        send_byte(8'h20, 1, 0);
        chk("t1_start_early", bus.o_Tx_Start, 0);
        step(0, 0, 8'h00);
        chk("t1_start_at_2", bus.o_Tx_Start, 1);
        chk("t1_tx_byte", bus.o_Tx_Byte, 8'h08);
        chk("t1_A", bus.o_A, 8'h05);
        chk("t1_B", bus.o_B, 8'h03);
        chk("t1_Op", bus.o_Op, 6'h20);
        step(0, 0, 8'h00);
        chk("t1_start_single", bus.o_Tx_Start, 0);
        wait_idle(20);

        // Long done level counts once.
        s0 = n_start;
        send_byte(8'hAA, 5, 0);
        idle(2, 0);
        chk("t2_A", bus.o_A, 8'hAA);
        chk("t2_busy", bus.o_Busy, 1);
        send_byte(8'hBB, 1, 0);
        chk("t2_B", bus.o_B, 8'hBB);
        send_byte(8'h26, 1, 0);
        wait_idle(30);
        chk("t2_one_start", n_start - s0, 1);
        chk("t2_tx_byte", bus.o_Tx_Byte, 8'h11);

        // Timeout after TT ticks.
        t0 = n_tout;
        send_byte(8'h11, 1, 0);
        idle(TT - 1, 100);
        chk("t3_busy_before", bus.o_Busy, 1);
        idle(1, 100);
        step(0, 0, 8'h00);
        chk("t3_timeout_pulse", bus.o_Err_Timeout, 1);
        chk("t3_busy_after", bus.o_Busy, 0);
        chk("t3_A_kept", bus.o_A, 8'h11);
        step(0, 0, 8'h00);
        chk("t3_one_timeout", n_tout - t0, 1);
        send_byte(8'h07, 1, 0);
        send_byte(8'h09, 1, 0);
        send_byte(8'h22, 1, 0);
        wait_idle(30);
        chk("t3_new_frame", bus.o_Tx_Byte, 8'hFE);

        // Overrun during transmit wait.
        tx_delay = 20;
        s0 = n_start;
        o0 = n_ovr;
        send_byte(8'h10, 1, 0);
        send_byte(8'h0F, 1, 0);
        send_byte(8'h24, 1, 0);
        k = 0;
        while (n_start == s0 && k < 10) begin
            step(0, 0, 8'h00);
            k++;
        end
        chk("t4_start_seen", n_start - s0, 1);
        send_byte(8'h55, 1, 0);
        idle(2, 0);
        chk("t4_overrun", n_ovr - o0, 1);
        chk("t4_busy", bus.o_Busy, 1);
        wait_idle(40);
        chk("t4_no_second_start", n_start - s0, 1);
        tx_delay = 3;
        send_byte(8'h0C, 1, 0);
        send_byte(8'h0A, 1, 0);
        send_byte(8'h25, 1, 0);
        wait_idle(30);
        chk("t4_next_frame", bus.o_Tx_Byte, 8'h0E);
        chk("t4_next_A", bus.o_A, 8'h0C);

        // Reset in S_GET_OP.
        s0 = n_start;
        send_byte(8'h21, 1, 0);
        send_byte(8'h22, 1, 0);
        @(posedge i_Clock);
        #1 i_reset_n = 1'b0;
        #1;
        chk("t5_A", bus.o_A, 0);
        chk("t5_B", bus.o_B, 0);
        chk("t5_Op", bus.o_Op, 0);
        chk("t5_Tx_Byte", bus.o_Tx_Byte, 0);
        chk("t5_Busy", bus.o_Busy, 0);
        @(posedge i_Clock);
        #1 i_reset_n = 1'b1;
        idle(10, 50);
        chk("t5_no_start", n_start - s0, 0);
        chk("t5_idle", bus.o_Busy, 0);

        // Byte on the terminal tick wins.
        t0 = n_tout;
        send_byte(8'h31, 1, 0);
        idle(TT - 1, 100);
        step(1, 1, 8'h77);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("t6_B", bus.o_B, 8'h77);
        chk("t6_busy", bus.o_Busy, 1);
        chk("t6_no_timeout", n_tout - t0, 0);
        send_byte(8'h26, 1, 0);
        wait_idle(30);
        chk("t6_result", bus.o_Tx_Byte, 8'h46);

        // Randomized frames.
        for (int it = 0; it < 40; it++) begin
            tx_delay = $urandom_range(6, 1);
            if ($urandom_range(7, 0) == 0) begin
                send_byte(8'($urandom), $urandom_range(3, 1), 30);
                idle(200, 100);
            end
            for (int j = 0; j < 3; j++) begin
                send_byte(8'($urandom), $urandom_range(3, 1), 30);
                idle($urandom_range(4, 0), 30);
            end
            if ($urandom_range(3, 0) == 0) send_byte(8'($urandom), 1, 0);
            wait_idle(400);
        end

        idle(5, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents the three values to the ALU, captures the result and requests one byte transmission of it.
- Aborts partially received frames with a baud-tick timeout.

Parameters:
- Bits, 8, width of operands, result and UART bytes
- Op_Bits, 6, opcode width; taken from the low Op_Bits of the third byte
- Timeout_Ticks, 160, i_bd ticks allowed between frame bytes before abort (16x oversample x 10 bit times)

Ports:
- i_Clock  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_bd  in  1  baud-rate tick, one cycle wide
- i_Rx_Done  in  1  receiver byte-done; may stay high more than one cycle
- i_Rx_Byte  in  Bits  received byte, valid while i_Rx_Done high
- i_Alu_Result  in  Bits  combinational ALU result for o_A/o_B/o_Op
- i_Tx_Done  in  1  transmitter finished, one-cycle pulse
- o_A  out  Bits  operand A register
- o_B  out  Bits  operand B register
- o_Op  out  Op_Bits  opcode register
- o_Tx_Start  out  1  one-cycle transmit request
- o_Tx_Byte  out  Bits  byte to transmit (latched result)
- o_Busy  out  1  high in any state except S_GET_A
- o_Err_Timeout  out  1  one-cycle pulse on frame abort
- o_Err_Overrun  out  1  one-cycle pulse when a byte arrives during S_EXEC/S_SEND/S_WAIT_TX

Behaviour:
- Reset (async, i_reset_n=0):
  - State returns to S_GET_A immediately.
  - o_A, o_B, o_Op, o_Tx_Byte and the timeout counter go to 0.
  - All pulse outputs and o_Busy go to 0.
  - Reset mid-frame or mid-transmit discards everything; no o_Tx_Start is issued afterwards.
- Byte event:
  - Defined as the rising edge of i_Rx_Done (registered previous value).
  - A multi-cycle done level counts once.
  - i_Rx_Byte is sampled in the event cycle.
- States and transitions:
  - S_GET_A: on byte event, o_A <= byte, clear timer, go to S_GET_B.
  - S_GET_B: on byte event, o_B <= byte, clear timer, go to S_GET_OP.
  - S_GET_OP: on byte event, o_Op <= byte[Op_Bits-1:0], go to S_EXEC.
  - S_EXEC: one cycle. o_Tx_Byte <= i_Alu_Result. Go to S_SEND.
  - S_SEND: o_Tx_Start=1 for exactly this cycle. Go to S_WAIT_TX.
  - S_WAIT_TX: stay until i_Tx_Done=1, then go to S_GET_A.
  - Undefined state encodings go to S_GET_A.
- Latency: last opcode byte event -> o_Tx_Start high is exactly 2 cycles.
- Timeout:
  - Counter active only in S_GET_B and S_GET_OP.
  - Increments on i_bd; saturates; cleared on entering these states and on each byte event.
  - When count reaches Timeout_Ticks with no byte event that cycle: pulse o_Err_Timeout, go to S_GET_A.
  - o_A, o_B and o_Op keep their last values.
  - Simultaneous byte event and terminal tick: the byte event wins, no error.
- Overrun:
  - A byte event in S_EXEC, S_SEND or S_WAIT_TX is dropped and pulses o_Err_Overrun.
  - State is unaffected.
- Simultaneous i_Tx_Done and byte event in S_WAIT_TX: go to S_GET_A, byte dropped, o_Err_Overrun pulses.
- o_A, o_B and o_Op hold stable from S_EXEC until the next frame overwrites them.
- No arithmetic other than the counter, which is $clog2(Timeout_Ticks+1) bits wide.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 with ALU model returning 0x08 -> o_A=0x05, o_B=0x03, o_Op=0x20; o_Tx_Start single pulse 2 cycles after third done edge; o_Tx_Byte=0x08; i_Tx_Done returns to S_GET_A, o_Busy=0.
- i_Rx_Done held high 5 cycles with byte 0xAA in S_GET_A -> only o_A=0xAA captured; state S_GET_B, not S_GET_OP.
- Byte 0x11, then 160 i_bd ticks with no byte -> o_Err_Timeout one-cycle pulse; state S_GET_A; o_A still 0x11; next three bytes form a full new frame.
- Byte event in S_WAIT_TX, before i_Tx_Done -> o_Err_Overrun pulse; no second o_Tx_Start; next frame processed normally.
- i_reset_n low for 1 cycle while in S_GET_OP -> all outputs 0 asynchronously; no o_Tx_Start afterwards.
- Byte event coincident with the 160th tick in S_GET_B -> byte captured in o_B, no o_Err_Timeout, state S_GET_OP.
